// File: rtl/disp_scan_status.sv
// Debounced water-level / valve / pump status shown on a multiplexed, active-low 7-segment display.
// Optional macro DISP_ERR_BLINK_EN blinks the level digit while it shows the error glyph "E".
module disp_scan_status #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int STABLE_CYC  = 1000,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              h,
  input  logic              m,
  input  logic              l,
  input  logic              vs,
  input  logic              bs,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              e,
  output logic              f,
  output logic              g,
  output logic [DIGITS-1:0] rd
);

  localparam int IW = $clog2(DIGITS);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int SW = $clog2(STABLE_CYC + 1);

  // Segment patterns ordered a..g, 0 = segment lit
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [4:0]        sample;
  logic [4:0]        raw_q, raw_d;
  logic [4:0]        commit_q, commit_d;
  logic [SW-1:0]     filt_q, filt_d;
  logic [RW-1:0]     ref_q, ref_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] rd_q, rd_d;
  logic [6:0]        seg_q, seg_d;
  logic [6:0]        levelGlyph, digitGlyph;

  assign sample = {h, m, l, vs, bs};

  // filt_q == STABLE_CYC-1 means raw_q has held its value for STABLE_CYC cycles
  always_comb begin
    raw_d    = sample;
    filt_d   = filt_q;
    commit_d = commit_q;
    if (sample != raw_q) begin
      filt_d = '0;
    end else if (filt_q != SW'(STABLE_CYC - 1)) begin
      filt_d = filt_q + 1'b1;
    end
    if (filt_q == SW'(STABLE_CYC - 1)) begin
      commit_d = raw_q;
    end
  end

  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef DISP_ERR_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;

  always_comb begin
    blink_d = blink_q + 1'b1;
    phase_d = phase_q;
    if (blink_q == BW'(BLINK_DIV - 1)) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= '0;
      phase_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
  end
`endif

  always_comb begin
    unique case (commit_q[4:2])
      3'b000:  levelGlyph = SEG_0;
      3'b001:  levelGlyph = SEG_1;
      3'b011:  levelGlyph = SEG_2;
      3'b111:  levelGlyph = SEG_3;
      default: levelGlyph = SEG_E;
    endcase

    digitGlyph = SEG_BLANK;
    if (idx_q == IW'(0)) begin
      digitGlyph = levelGlyph;
    end else if (idx_q == IW'(1)) begin
      digitGlyph = commit_q[1] ? SEG_A : SEG_F;
    end else if (idx_q == IW'(2)) begin
      digitGlyph = commit_q[0] ? SEG_L : SEG_D;
    end
`ifdef DISP_ERR_BLINK_EN
    if ((idx_q == IW'(0)) && (levelGlyph == SEG_E) && phase_q) begin
      digitGlyph = SEG_BLANK;
    end
`endif

    rd_d  = '1;
    seg_d = SEG_BLANK;
    if (en) begin
      rd_d  = ~(DIGITS'(1) << idx_q);
      seg_d = digitGlyph;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q    <= '0;
      commit_q <= '0;
      filt_q   <= '0;
      ref_q    <= '0;
      idx_q    <= '0;
      rd_q     <= '1;
      seg_q    <= SEG_BLANK;
    end else begin
      raw_q    <= raw_d;
      commit_q <= commit_d;
      filt_q   <= filt_d;
      ref_q    <= ref_d;
      idx_q    <= idx_d;
      rd_q     <= rd_d;
      seg_q    <= seg_d;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign rd = rd_q;

endmodule

// File: tb/tb_disp_scan_status.sv
// Randomised self-checking bench for disp_scan_status against a cycle-level behavioural model.
// Honours DISP_ERR_BLINK_EN the same way the design does.
module tb_disp_scan_status;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;
  localparam int STABLE_CYC  = 3;
  localparam int BLINK_DIV   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic              h = 1'b0, m = 1'b0, l = 1'b0, vs = 1'b0, bs = 1'b0;
  logic              a, b, c, d, e, f, g;
  logic [DIGITS-1:0] rd;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: edges since reset, history of the registered raw vector, committed vector
  int                n;
  logic [4:0]        hist[$];
  logic [4:0]        committed;
  logic [DIGITS-1:0] expRd;
  logic [6:0]        expSeg;

  disp_scan_status #(
    .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV),
    .STABLE_CYC(STABLE_CYC), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .h(h), .m(m), .l(l), .vs(vs), .bs(bs),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .rd(rd)
  );

  always #5 clk = ~clk;

  // Turn a list of lit segment letters into the active-low a..g vector
  function automatic logic [6:0] litToSegs(input string lit);
    logic [6:0] segs = 7'b1111111;
    for (int i = 0; i < lit.len(); i++) begin
      segs[6 - (lit[i] - "a")] = 1'b0;
    end
    return segs;
  endfunction

  function automatic logic [6:0] glyphSegs(input int idx, input logic [4:0] cv, input int phase);
    byte   ch;
    string lit;
    case (idx)
      0: begin
        case (cv[4:2])
          3'b000:  ch = "0";
          3'b001:  ch = "1";
          3'b011:  ch = "2";
          3'b111:  ch = "3";
          default: ch = "E";
        endcase
`ifdef DISP_ERR_BLINK_EN
        if (ch == "E" && phase == 1) ch = " ";
`endif
      end
      1:       ch = cv[1] ? "A" : "F";
      2:       ch = cv[0] ? "L" : "d";
      default: ch = " ";
    endcase
    case (ch)
      "0":     lit = "abcdef";
      "1":     lit = "bc";
      "2":     lit = "abdeg";
      "3":     lit = "abcdg";
      "E":     lit = "adefg";
      "A":     lit = "abcefg";
      "F":     lit = "aefg";
      "L":     lit = "def";
      "d":     lit = "bcdeg";
      default: lit = "";
    endcase
    return litToSegs(lit);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven, then step the DUT
  task automatic tick();
    int  idx, phase;
    logic allEq;
    if (rst) begin
      n = 0;
      hist.delete();
      for (int i = 0; i < STABLE_CYC; i++) hist.push_back(5'b0);
      committed = 5'b0;
      expRd     = '1;
      expSeg    = 7'b1111111;
    end else begin
      idx   = (n / REFRESH_DIV) % DIGITS;
      phase = (n / BLINK_DIV) % 2;
      if (en) begin
        expRd      = '1;
        expRd[idx] = 1'b0;
        expSeg     = glyphSegs(idx, committed, phase);
      end else begin
        expRd  = '1;
        expSeg = 7'b1111111;
      end
      allEq = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) allEq = 1'b0;
      if (allEq) committed = hist[0];
      hist.push_back({h, m, l, vs, bs});
      void'(hist.pop_front());
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setSensors(input logic [2:0] hml, input logic v, input logic p);
    {h, m, l} = hml;
    vs = v;
    bs = p;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; setSensors(3'b101, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({rd, a, b, c, d, e, f, g} !== {4'b1111, 7'b1111111}) begin
        miscompares++;
        $display("[TB] FAIL reset_hold rd=%b seg=%b%b%b%b%b%b%b want rd=1111 seg=1111111", rd, a, b, c, d, e, f, g);
      end
    end
    setSensors(3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    vectors++;
    if ({rd, a, b, c, d, e, f, g} !== {4'b1110, 7'b0000001}) begin
      miscompares++;
      $display("[TB] FAIL reset_release rd=%b seg=%b%b%b%b%b%b%b want rd=1110 seg=0000001", rd, a, b, c, d, e, f, g);
    end
  endtask

  task automatic test_scan();
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if ({rd, a, b, c, d, e, f, g} !== {expRd, expSeg}) begin
        miscompares++;
        $display("[TB] FAIL scan cyc=%0d rd=%b seg=%b%b%b%b%b%b%b want rd=%b seg=%b", i, rd, a, b, c, d, e, f, g, expRd, expSeg);
      end
    end
  endtask

  task automatic test_filter();
    logic [2:0] pattern[4] = '{3'b011, 3'b111, 3'b011, 3'b011};
    int         holdCyc[4] = '{6, 2, 4, 16};
    for (int p = 0; p < 4; p++) begin
      setSensors(pattern[p], 1'b0, 1'b0);
      for (int i = 0; i < holdCyc[p]; i++) begin
        tick();
        vectors++;
        if ({rd, a, b, c, d, e, f, g} !== {expRd, expSeg}) begin
          miscompares++;
          $display("[TB] FAIL filter p=%0d cyc=%0d rd=%b seg=%b%b%b%b%b%b%b want rd=%b seg=%b", p, i, rd, a, b, c, d, e, f, g, expRd, expSeg);
        end
      end
    end
  endtask

  task automatic test_valve_pump();
    setSensors(3'b011, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) begin
      tick();
      vectors++;
      if ({rd, a, b, c, d, e, f, g} !== {expRd, expSeg}) begin
        miscompares++;
        $display("[TB] FAIL valve_pump cyc=%0d rd=%b seg=%b%b%b%b%b%b%b want rd=%b seg=%b", i, rd, a, b, c, d, e, f, g, expRd, expSeg);
      end
    end
  endtask

  task automatic test_error_blink();
    setSensors(3'b100, 1'b0, 1'b1);
    for (int i = 0; i < 48; i++) begin
      tick();
      vectors++;
      if ({rd, a, b, c, d, e, f, g} !== {expRd, expSeg}) begin
        miscompares++;
        $display("[TB] FAIL error_blink cyc=%0d rd=%b seg=%b%b%b%b%b%b%b want rd=%b seg=%b", i, rd, a, b, c, d, e, f, g, expRd, expSeg);
      end
    end
  endtask

  task automatic test_enable();
    setSensors(3'b001, 1'b1, 1'b0);
    for (int i = 0; i < 22; i++) begin
      en = (i >= 5 && i < 11) ? 1'b0 : 1'b1;
      tick();
      vectors++;
      if ({rd, a, b, c, d, e, f, g} !== {expRd, expSeg}) begin
        miscompares++;
        $display("[TB] FAIL enable cyc=%0d en=%b rd=%b seg=%b%b%b%b%b%b%b want rd=%b seg=%b", i, en, rd, a, b, c, d, e, f, g, expRd, expSeg);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_midscan();
    int guard = 0;
    setSensors(3'b111, 1'b1, 1'b1);
    while (((n / REFRESH_DIV) % DIGITS) != 2 && guard < 64) begin
      tick();
      guard++;
    end
    if (guard >= 64) begin
      miscompares++;
      $display("[TB] FAIL midscan_reach idx=%0d want 2", (n / REFRESH_DIV) % DIGITS);
    end
    setSensors(3'b011, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    setSensors(3'b000, 1'b0, 1'b0);
    tick();
    vectors++;
    if ({rd, a, b, c, d, e, f, g} !== {4'b1110, 7'b0000001}) begin
      miscompares++;
      $display("[TB] FAIL midscan_reset rd=%b seg=%b%b%b%b%b%b%b want rd=1110 seg=0000001", rd, a, b, c, d, e, f, g);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if ({rd, a, b, c, d, e, f, g} !== {expRd, expSeg}) begin
        miscompares++;
        $display("[TB] FAIL midscan_after cyc=%0d rd=%b seg=%b%b%b%b%b%b%b want rd=%b seg=%b", i, rd, a, b, c, d, e, f, g, expRd, expSeg);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        setSensors(3'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        hold = $urandom_range(1, 7);
      end
      hold--;
      en  = ($urandom_range(9) != 0);
      rst = ($urandom_range(99) == 0);
      tick();
      vectors++;
      if ({rd, a, b, c, d, e, f, g} !== {expRd, expSeg}) begin
        miscompares++;
        $display("[TB] FAIL random cyc=%0d rd=%b seg=%b%b%b%b%b%b%b want rd=%b seg=%b", i, rd, a, b, c, d, e, f, g, expRd, expSeg);
      end
    end
    rst = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_filter();
    test_valve_pump();
    test_error_blink();
    test_enable();
    test_reset_midscan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/disp_scan_status.md
DISP_SCAN_STATUS -- requirements
Module: disp_scan_status

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits; legal range 3..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clock cycles each digit stays enabled; must be at least 1.
REQ-003 Parameter STABLE_CYC, default 1000: consecutive equal samples required to accept a sensor change; must be at least 1.
REQ-004 Parameter BLINK_DIV, default 12500000: cycles per blink half-period.
REQ-005 Port clk, input, 1 bit: the single clock.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port en, input, 1 bit: display enable; 0 = all digits off.
REQ-008 Ports h, m, l, input, 1 bit each: high / medium / low water-level sensors.
REQ-009 Port vs, input, 1 bit: valve state; 1 = open.
REQ-010 Port bs, input, 1 bit: pump state; 1 = on.
REQ-011 Ports a, b, c, d, e, f, g, output, 1 bit each: segment drives, active-low.
REQ-012 Port rd, output, DIGITS bits: digit enables, active-low; rd[i] = 1 turns digit i off.

Function
REQ-013 Input filter: raw vector {h,m,l,vs,bs} SHALL be registered; the committed vector SHALL update only after the raw vector holds one value for STABLE_CYC consecutive cycles; any change restarts the count at 0.
REQ-014 Level decode from committed {h,m,l}: 000 -> "0"; 001 -> "1"; 011 -> "2"; 111 -> "3"; every other code -> "E" (error).
REQ-015 Digit 0 SHALL show the level glyph; digit 1 SHALL show "A" if vs=1, else "F"; digit 2 SHALL show "L" if bs=1, else "d"; digits 3..DIGITS-1 SHALL be blank.
REQ-016 Lit segment sets (a..g): 0 = abcdef; 1 = bc; 2 = abdeg; 3 = abcdg; E = adefg; A = abcefg; F = aefg; L = def; d = bcdeg; blank = none.
REQ-017 Scan: the refresh counter runs 0..REFRESH_DIV-1; on terminal count the digit index SHALL advance by 1 and wrap from DIGITS-1 to 0.
REQ-018 Exactly one rd bit SHALL be low when en=1, selecting the current index; the segment outputs SHALL carry that digit's glyph in the same cycle.
REQ-019 When en=0, all rd bits and all segments SHALL be 1; the scan counters SHALL keep running.
REQ-020 Outputs SHALL be registered, giving one cycle of latency from index or committed-value change to the pins.
REQ-021 A sensor change during a digit's active window SHALL update that digit immediately after commit (plus the REQ-020 latency), without waiting for the next scan.

Reset
REQ-022 While rst=1: refresh counter, digit index, filter count and blink phase SHALL be 0; committed and raw registers SHALL be 00000; all rd and segment outputs SHALL be 1.
REQ-023 On the first clock edge after rst falls with en=1, rd[0] SHALL go low showing "0".
REQ-024 Reset asserted mid-scan or mid-filter SHALL abort the operation with no residual state.

Configuration
REQ-025 Macro DISP_ERR_BLINK_EN defined:
  - A blink phase SHALL toggle every BLINK_DIV cycles.
  - While the level is "E" and the phase is 1, digit 0 segments SHALL be all off.
  - rd SHALL still scan normally.
  - Non-error glyphs SHALL be unaffected.
REQ-026 Macro undefined: "E" SHALL be shown steadily, and no blink counter SHALL be synthesised.

Verification
(Bench parameters: DIGITS=4, REFRESH_DIV=4, STABLE_CYC=3, BLINK_DIV=8.)
REQ-027 Reset then en=1 -> rd cycles 1110, 1101, 1011, 0111, 1110, each for 4 cycles; digit glyphs 0, F, d, blank.
REQ-028 {h,m,l}=011 held 3 cycles -> digit 0 becomes abdeg lit (a..g = 0010010); a 2-cycle glitch to 111 -> no change.
REQ-029 vs=1, bs=1 stable -> digit 1 shows a..g = 0001000, digit 2 shows a..g = 1110001.
REQ-030 {h,m,l}=100 with DISP_ERR_BLINK_EN -> digit 0 alternates 0110000 and 1111111 every 8 cycles; without the macro -> steady 0110000.
REQ-031 en=0 mid-scan for 6 cycles -> all outputs 1; on en=1 -> scan resumes at the index reached by the free-running counter.
REQ-032 rst pulsed mid-scan at index 2 -> next active digit is 0, filter reset, digit 0 shows "0".
